// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state and op encoding
// for the add/sub arbiter slice.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: requester and response bundle.
// rsp_ovf exists only with ADDSUB_ARB_OVF_EN.
interface addsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_s;
`ifdef ADDSUB_ARB_OVF_EN
  logic              rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_op,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_s, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_s, rsp_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_s
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_s
  );
`endif

endinterface

// File: rtl/AddOrSub.sv
// AddOrSub: shared W-bit adder/subtractor,
// result wraps modulo 2^W.
module AddOrSub
  import addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] s
);

  // add or two's-complement subtract
  always_comb begin
    s = (op == OP_SUB) ? a - b : a + b;
  end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one AddOrSub.
// Macro ADDSUB_ARB_OVF_EN adds the rsp_ovf flag.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input logic             clk,
  input logic             rst,
  addsub_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] g_q;
  logic           hs;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           op_q;
  logic [W-1:0]   sum;

  function automatic logic [IDW-1:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  p
  );
    logic [IDW-1:0] r;
    int             k;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NREQ;
      if (v[IDW'(k)]) r = IDW'(k);
    end
    return r;
  endfunction

  AddOrSub #(.W(W)) u_addsub (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .s  (sum)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and grant; ready never sees rsp_ready
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    hs            = 1'b0;
    gnt           = rr_pick(bus.req_valid, ptr);
    unique case (state)
      IDLE: begin
        if (!rst && |bus.req_valid) begin
          bus.req_ready = NREQ'(1) << gnt;
          hs            = 1'b1;
          state_nxt     = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, result register, rotation pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= OP_ADD;
      g_q           <= '0;
      ptr           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_s     <= '0;
      bus.rsp_id    <= '0;
`ifdef ADDSUB_ARB_OVF_EN
      bus.rsp_ovf   <= 1'b0;
`endif
    end else begin
      if (hs) begin
        a_q  <= W'(bus.req_a >> (W * int'(gnt)));
        b_q  <= W'(bus.req_b >> (W * int'(gnt)));
        op_q <= bus.req_op[gnt];
        g_q  <= gnt;
      end
      if (state == EXEC) begin
        bus.rsp_s     <= sum;
        bus.rsp_id    <= g_q;
        bus.rsp_valid <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
        bus.rsp_ovf <= (op_q == OP_SUB)
          ? (a_q[W-1] != b_q[W-1]) & (sum[W-1] != a_q[W-1])
          : (a_q[W-1] == b_q[W-1]) & (sum[W-1] != a_q[W-1]);
`endif
      end
      if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        ptr <= (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed + random stimulus,
// queue scoreboard against an arithmetic reference.
module tb_addsub_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [W-1:0] s;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [NREQ-1:0] va  = '0;
  logic [NREQ-1:0] opv = '0;
  logic [W-1:0]    av[NREQ];
  logic [W-1:0]    bv[NREQ];
  logic            rr    = 1'b1;
  logic            rst_d = 1'b1;

  int m_phase = 0;
  int m_ptr   = 0;
  int m_g     = 0;

  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  function automatic exp_t ref_op(int id, logic [W-1:0] a,
                                  logic [W-1:0] b, logic op,
                                  int due);
    exp_t e;
    int   sa, sb, r, u;
    sa = (int'(a) > 127) ? int'(a) - 256 : int'(a);
    sb = (int'(b) > 127) ? int'(b) - 256 : int'(b);
    r  = op ? sa - sb : sa + sb;
    u  = op ? int'(a) - int'(b) + 256 : int'(a) + int'(b);
    e.id  = id;
    e.s   = W'(u % 256);
    e.ovf = (r > 127) || (r < -128);
    e.due = due;
    return e;
  endfunction

  // one cycle: drive at negedge, predict and check ready
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int              k;
    bit              found;
    @(negedge clk);
    rst           = rst_d;
    bus.req_valid = va;
    bus.req_op    = opv;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*W +: W] = av[i];
      bus.req_b[i*W +: W] = bv[i];
    end
    #1;
    exp_rdy = '0;
    if (rst_d) begin
      m_phase = 0;
      m_ptr   = 0;
      q.delete();
    end else begin
      case (m_phase)
        0: begin
          found = 0;
          for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (!found && va[k]) begin
              found = 1;
              m_g   = k;
            end
          end
          if (found) begin
            exp_rdy[m_g] = 1'b1;
            q.push_back(ref_op(m_g, av[m_g], bv[m_g],
                               opv[m_g], cyc + 2));
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (rr) begin
            m_ptr   = (m_g + 1) % NREQ;
            m_phase = 0;
          end
        end
      endcase
    end
    check("req_ready", int'(bus.req_ready), int'(exp_rdy));
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i]) va[i] = 1'b0;
  endtask

  task automatic set_req(int i, logic [W-1:0] a,
                         logic [W-1:0] b, logic op);
    va[i]  = 1'b1;
    av[i]  = a;
    bv[i]  = b;
    opv[i] = op;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // response monitor
  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          check("spurious_rsp", 1, 0);
        end else begin
          if (!pv) check("rsp_latency", cyc, q[0].due);
          check("rsp_id", int'(bus.rsp_id), q[0].id);
          check("rsp_s", int'(bus.rsp_s), int'(q[0].s));
`ifdef ADDSUB_ARB_OVF_EN
          check("rsp_ovf", int'(bus.rsp_ovf), int'(q[0].ovf));
`endif
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        check("rsp_late", 0, 1);
      end
      pv = bus.rsp_valid && !bus.rsp_ready;
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // reset with a request pending
    set_req(0, 8'hFF, 8'hFF, 1'b0);
    rst_d = 1'b1;
    step();
    step();
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_s", int'(bus.rsp_s), 0);
    check("rst_rsp_id", int'(bus.rsp_id), 0);
`ifdef ADDSUB_ARB_OVF_EN
    check("rst_rsp_ovf", int'(bus.rsp_ovf), 0);
`endif
    rst_d = 1'b0;
    idle(4);

    set_req(2, 8'hFE, 8'h10, 1'b1);
    idle(4);
    set_req(1, 8'h7F, 8'h01, 1'b0);
    idle(4);
    set_req(3, 8'h80, 8'h01, 1'b1);
    idle(4);

    // fairness: everyone always valid
    for (int i = 0; i < NREQ; i++)
      set_req(i, W'($urandom), W'($urandom), 1'($urandom));
    for (int n = 0; n < 15; n++) begin
      va = '1;
      step();
    end
    va = '0;
    idle(4);

    // backpressure with a competitor waiting
    set_req(1, 8'h55, 8'hAA, 1'b0);
    set_req(3, 8'h01, 8'h02, 1'b1);
    rr = 1'b0;
    idle(8);
    rr = 1'b1;
    idle(6);
    set_req(1, 8'h10, 8'h20, 1'b1);
    idle(4);

    // reset while an op is in EXEC
    set_req(2, 8'h33, 8'h44, 1'b0);
    step();
    rst_d = 1'b1;
    step();
    step();
    rst_d = 1'b0;
    idle(4);
    for (int i = 0; i < NREQ; i++)
      set_req(i, W'($urandom), W'($urandom), 1'($urandom));
    step();
    va = '0;
    idle(4);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (va[i]) begin
          if ($urandom % 16 == 0) va[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          set_req(i, W'($urandom), W'($urandom), 1'($urandom));
        end
      end
      rr = ($urandom % 4) != 0;
      step();
    end

    // drain with a bound
    va = '0;
    rr = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) step();
    step();
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
